ln_seq: RTL

- Iterative natural-logarithm unit; the inverse of the exponential datapath.
- Input is an unsigned Q16.16 operand. Output is signed Q16.16 ln(x).
- Method: leading-one normalisation, then log2 by repeated squaring, then scaling by ln2.
- Sits beside the exp / multiply / divide blocks and uses a start/busy/done handshake so a sequencer can chain operations.

---
 rtl/ln_seq.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ln_seq.sv
// Iterative natural logarithm: unsigned Q16.16 in, signed Q16.16 ln(x) out.
// Define LN_ROUND_EN for round-half-up scaling instead of floor.
module ln_seq #(
   parameter int ITERS   = 16,
   parameter int LN2_Q16 = 45426
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] x,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] result
);

   // Handshake: start is sampled only in IDLE; busy is high from the cycle
   // after acceptance until done; done is a one-cycle pulse with result/err valid.
   typedef enum logic [1:0] {S_IDLE, S_NORM, S_SQR, S_SCALE} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [31:0]        r_x;
   logic [31:0]        r_m;
   logic [31:0]        r_acc;
   logic [4:0]         r_i;
   logic               r_err_pend;
   logic               r_busy;
   logic               r_done;
   logic               r_err;
   logic [31:0]        r_result;

   logic               w_accept;
   logic               w_last_sqr;
   logic [4:0]         w_p;
   logic [4:0]         w_shift;
   logic [5:0]         w_k;
   logic [31:0]        w_m_norm;
   logic [31:0]        w_acc_norm;
   logic [63:0]        w_sq;
   logic [31:0]        w_bit;
   logic signed [48:0] w_acc_ext;
   logic signed [48:0] w_ln2;
   logic signed [48:0] w_prod;
   logic signed [48:0] w_prod_r;
   logic [31:0]        w_scaled;
   logic               w_unused;

   assign busy   = r_busy;
   assign done   = r_done;
   assign err    = r_err;
   assign result = r_result;

   // Leading-one position of the captured operand
   always_comb begin
      w_p = 5'd0;
      for (int b = 0; b < 32; b++) begin
         if (r_x[b]) w_p = 5'(b);
      end
   end

   assign w_shift    = 5'd31 - w_p;
   assign w_m_norm   = r_x << w_shift;
   assign w_k        = {1'b0, w_p} - 6'd16;
   assign w_acc_norm = {{10{w_k[5]}}, w_k, 16'h0000};

   assign w_sq  = 64'(r_m) * 64'(r_m);
   assign w_bit = 32'h0000_8000 >> r_i;

   assign w_acc_ext = {{17{r_acc[31]}}, r_acc};
   assign w_ln2     = 49'(LN2_Q16);
   assign w_prod    = w_acc_ext * w_ln2;

`ifdef LN_ROUND_EN
   assign w_prod_r = w_prod + 49'sd32768;
`else
   assign w_prod_r = w_prod;
`endif

   assign w_scaled = w_prod_r[47:16];
   assign w_unused = ^{w_sq[30:0], w_prod_r[48], w_prod_r[15:0]};

   assign w_accept   = (r_state == S_IDLE) && start;
   assign w_last_sqr = (r_state == S_SQR) && (r_i == 5'(ITERS - 1));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_NORM;
         S_NORM:  w_next = S_SQR;
         S_SQR:   if (w_last_sqr) w_next = S_SCALE;
         S_SCALE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_x        <= 32'h0;
         r_m        <= 32'h0;
         r_acc      <= 32'h0;
         r_i        <= 5'd0;
         r_err_pend <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_result   <= 32'h0;
      end else begin
         r_state <= w_next;
         r_done  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_x    <= x;
                  r_busy <= 1'b1;
                  r_err  <= 1'b0;
               end
            end
            S_NORM: begin
               r_i <= 5'd0;
               // A zero operand still walks through SQR with m=0 so latency is fixed
               if (r_x == 32'h0) begin
                  r_err_pend <= 1'b1;
                  r_m        <= 32'h0;
                  r_acc      <= 32'h0;
               end else begin
                  r_err_pend <= 1'b0;
                  r_m        <= w_m_norm;
                  r_acc      <= w_acc_norm;
               end
            end
            S_SQR: begin
               if (w_sq[63]) begin
                  r_m   <= w_sq[63:32];
                  r_acc <= r_acc | w_bit;
               end else begin
                  r_m   <= w_sq[62:31];
               end
               r_i <= r_i + 5'd1;
            end
            S_SCALE: begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
               if (r_err_pend) begin
                  r_result <= 32'h8000_0000;
                  r_err    <= 1'b1;
               end else begin
                  r_result <= w_scaled;
                  r_err    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
